// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep sequencer driving the DDS inc_phi/occupation/waveform controls.
// Steps run f_start..f_stop by f_step with a per-step dwell, repeat passes and optional tongbu alignment.
module dds_sweep_ctrl #(
    parameter int DWELL_W = 24,
    parameter bit ALIGN   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_f_start,
    input  logic [31:0]        cfg_f_stop,
    input  logic [31:0]        cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [7:0]         cfg_repeat,
    input  logic [3:0]         cfg_waveform,
    input  logic [3:0]         cfg_occupation,
    input  logic               start,
    input  logic               abort,
    input  logic               tongbu,
    output logic [31:0]        inc_phi,
    output logic [3:0]         occupation,
    output logic [3:0]         waveform,
    output logic               busy,
    output logic               step_strobe,
    output logic               sweep_done,
    output logic               cfg_err
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_SYNC, DONE} state_t;
    state_t r_state, w_state;
    logic [31:0] r_f_start, r_f_stop, r_f_step, w_f_start, w_f_stop, w_f_step;
    logic [DWELL_W-1:0] r_dwell, w_dwell, r_dwell_cnt, w_dwell_cnt, w_reload;
    logic [7:0] r_repeat, w_repeat, r_passes, w_passes;
    logic [3:0] r_wave_sh, w_wave_sh, r_occ_sh, w_occ_sh, r_wave, w_wave, r_occ, w_occ;
    logic r_loaded, w_loaded, w_hs;
    logic [31:0] r_inc_phi, w_inc_phi, r_target, w_target, w_tgt;
    logic [32:0] w_sum;
    logic w_eop, r_step, w_step, r_done, w_done, r_err, w_err;
    assign w_hs      = cfg_valid && r_state == IDLE;
    // A config accepted in the same cycle as start is the one the start uses.
    assign w_f_start = w_hs ? cfg_f_start : r_f_start;
    assign w_f_stop  = w_hs ? cfg_f_stop : r_f_stop;
    assign w_f_step  = w_hs ? cfg_f_step : r_f_step;
    assign w_dwell   = w_hs ? cfg_dwell : r_dwell;
    assign w_repeat  = w_hs ? cfg_repeat : r_repeat;
    assign w_wave_sh = w_hs ? cfg_waveform : r_wave_sh;
    assign w_occ_sh  = w_hs ? cfg_occupation : r_occ_sh;
    assign w_loaded  = w_hs || r_loaded;
    assign w_reload  = (w_dwell == '0) ? '0 : w_dwell - 1'b1;
    // 33-bit sum so a step past 2^32-1 ends the pass instead of wrapping.
    assign w_sum     = {1'b0, r_inc_phi} + {1'b0, r_f_step};
    assign w_eop     = (r_f_step == '0) || (w_sum > {1'b0, r_f_stop});
    assign w_tgt     = w_eop ? r_f_start : w_sum[31:0];
    always_comb begin
        w_state     = r_state;
        w_inc_phi   = r_inc_phi;
        w_occ       = r_occ;
        w_wave      = r_wave;
        w_passes    = r_passes;
        w_dwell_cnt = r_dwell_cnt;
        w_target    = r_target;
        w_step      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (abort) begin
            w_state   = IDLE;
            w_inc_phi = '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    if (!w_loaded || w_f_start > w_f_stop) begin
                        w_err = 1'b1;
                    end else begin
                        w_state     = RUN;
                        w_inc_phi   = w_f_start;
                        w_occ       = w_occ_sh;
                        w_wave      = w_wave_sh;
                        w_passes    = w_repeat;
                        w_dwell_cnt = w_reload;
                        w_step      = 1'b1;
                    end
                end
                RUN: if (r_dwell_cnt != '0) begin
                    w_dwell_cnt = r_dwell_cnt - 1'b1;
                end else if (w_eop && r_passes == '0) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                end else begin
                    if (w_eop) w_passes = r_passes - 1'b1;
                    if (ALIGN) begin
                        w_target = w_tgt;
                        w_state  = WAIT_SYNC;
                    end else begin
                        w_inc_phi   = w_tgt;
                        w_step      = 1'b1;
                        w_dwell_cnt = w_reload;
                    end
                end
                WAIT_SYNC: if (tongbu) begin
                    w_inc_phi   = r_target;
                    w_step      = 1'b1;
                    w_dwell_cnt = w_reload;
                    w_state     = RUN;
                end
                default: w_state = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_f_start   <= '0;
            r_f_stop    <= '0;
            r_f_step    <= '0;
            r_dwell     <= '0;
            r_repeat    <= '0;
            r_wave_sh   <= '0;
            r_occ_sh    <= '0;
            r_loaded    <= 1'b0;
            r_inc_phi   <= '0;
            r_occ       <= '0;
            r_wave      <= '0;
            r_passes    <= '0;
            r_dwell_cnt <= '0;
            r_target    <= '0;
            r_step      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_f_start   <= w_f_start;
            r_f_stop    <= w_f_stop;
            r_f_step    <= w_f_step;
            r_dwell     <= w_dwell;
            r_repeat    <= w_repeat;
            r_wave_sh   <= w_wave_sh;
            r_occ_sh    <= w_occ_sh;
            r_loaded    <= w_loaded;
            r_inc_phi   <= w_inc_phi;
            r_occ       <= w_occ;
            r_wave      <= w_wave;
            r_passes    <= w_passes;
            r_dwell_cnt <= w_dwell_cnt;
            r_target    <= w_target;
            r_step      <= w_step;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end
    assign cfg_ready   = r_state == IDLE;
    assign busy        = r_state == RUN || r_state == WAIT_SYNC;
    assign inc_phi     = r_inc_phi;
    assign occupation  = r_occ;
    assign waveform    = r_wave;
    assign step_strobe = r_step;
    assign sweep_done  = r_done;
    assign cfg_err     = r_err;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: randomized sweeps on an ALIGN=0 and an ALIGN=1 instance against a step-list/timing reference model.
module tb_dds_sweep_ctrl;
    logic clk = 1'b0, reset_n = 1'b0, cfg_valid = 1'b0, start = 1'b0, abort = 1'b0, tongbu = 1'b0;
    logic [31:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0;
    logic [23:0] cfg_dwell = '0;
    logic [7:0]  cfg_repeat = '0;
    logic [3:0]  cfg_waveform = '0, cfg_occupation = '0;
    logic [1:0]  cfg_ready, busy, step_strobe, sweep_done, cfg_err;
    logic [1:0][31:0] inc_phi;
    logic [1:0][3:0]  occupation, waveform;
    int n_chk = 0, n_fail = 0, tph = 0;
    logic [31:0] last_inc [2];
    always #5 clk = ~clk;
    dds_sweep_ctrl #(.DWELL_W(24), .ALIGN(1'b0)) u_a0 (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
        .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
        .cfg_dwell(cfg_dwell), .cfg_repeat(cfg_repeat), .cfg_waveform(cfg_waveform),
        .cfg_occupation(cfg_occupation), .start(start), .abort(abort), .tongbu(tongbu),
        .inc_phi(inc_phi[0]), .occupation(occupation[0]), .waveform(waveform[0]), .busy(busy[0]),
        .step_strobe(step_strobe[0]), .sweep_done(sweep_done[0]), .cfg_err(cfg_err[0]));
    dds_sweep_ctrl #(.DWELL_W(24), .ALIGN(1'b1)) u_a1 (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
        .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
        .cfg_dwell(cfg_dwell), .cfg_repeat(cfg_repeat), .cfg_waveform(cfg_waveform),
        .cfg_occupation(cfg_occupation), .start(start), .abort(abort), .tongbu(tongbu),
        .inc_phi(inc_phi[1]), .occupation(occupation[1]), .waveform(waveform[1]), .busy(busy[1]),
        .step_strobe(step_strobe[1]), .sweep_done(sweep_done[1]), .cfg_err(cfg_err[1]));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit tb_at(input int c);
        return (c % 10) == tph;
    endfunction
    task automatic set_cfg(input logic [31:0] fs, fe, st, input logic [23:0] dw, input logic [7:0] rep);
        cfg_f_start = fs;
        cfg_f_stop = fe;
        cfg_f_step = st;
        cfg_dwell = dw;
        cfg_repeat = rep;
        cfg_waveform = 4'($urandom);
        cfg_occupation = 4'($urandom);
    endtask
    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_inc"}, inc_phi[k], 0);
            chk({tag, "_occ_wave"}, {occupation[k], waveform[k]}, 0);
            chk({tag, "_flags"}, {busy[k], step_strobe[k], sweep_done[k], cfg_err[k], cfg_ready[k]}, 5'b00001);
        end
    endtask
    task automatic reject(input bit load, input logic [31:0] fs, fe);
        @(negedge clk);
        if (load) begin
            set_cfg(fs, fe, 32'd1, 24'd1, 8'd0);
            cfg_valid = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rej_err", cfg_err[k], 1);
            chk("rej_busy", busy[k], 0);
            chk("rej_inc", inc_phi[k], last_inc[k]);
            chk("rej_strobe", step_strobe[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("rej_err_pulse", cfg_err[k], 0);
    endtask
    task automatic run_sweep(input logic [31:0] fs, fe, st, input logic [23:0] dwi, input logic [7:0] rep, input bit same);
        logic [31:0] q[$];
        logic [32:0] nxt;
        logic [31:0] f;
        logic [31:0] cur [2];
        int dw, cyc, e;
        int ptr [2];
        int last [2];
        bit fin [2];
        for (int p = 0; p <= int'(rep); p++) begin
            f = fs;
            while (1) begin
                q.push_back(f);
                nxt = {1'b0, f} + {1'b0, st};
                if (st == 0 || nxt > {1'b0, fe}) break;
                f = nxt[31:0];
            end
        end
        dw = (dwi == 0) ? 1 : int'(dwi);
        tph = $urandom_range(0, 9);
        ptr = '{0, 0};
        last = '{0, 0};
        fin = '{0, 0};
        cur = '{0, 0};
        @(negedge clk);
        set_cfg(fs, fe, st, dwi, rep);
        cfg_valid = 1'b1;
        if (!same) begin
            @(negedge clk);
            cfg_valid = 1'b0;
        end
        start = 1'b1;
        cyc = 0;
        tongbu = tb_at(1);
        while (!(fin[0] && fin[1]) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            cfg_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (!fin[k]) begin
                    if (step_strobe[k]) begin
                        if (ptr[k] >= q.size()) chk("extra_strobe", ptr[k], q.size() - 1);
                        else chk("step_value", inc_phi[k], q[ptr[k]]);
                        if (ptr[k] == 0) e = 1;
                        else if (k == 0) e = last[k] + dw;
                        else begin
                            e = last[k] + dw + 1;
                            while (!tb_at(e)) e++;
                        end
                        chk("step_time", cyc, e);
                        chk("run_busy", busy[k], 1);
                        if (ptr[k] == 0) chk("occ_wave", {occupation[k], waveform[k]}, {cfg_occupation, cfg_waveform});
                        last[k] = cyc;
                        cur[k] = inc_phi[k];
                        ptr[k]++;
                    end else if (sweep_done[k]) begin
                        chk("step_count", ptr[k], q.size());
                        chk("done_time", cyc, last[k] + dw);
                        chk("done_inc", inc_phi[k], q[$]);
                        chk("done_busy", busy[k], 0);
                        fin[k] = 1'b1;
                    end else if (ptr[k] == 0) begin
                        chk("first_strobe", cyc, 1);
                    end else begin
                        chk("hold", inc_phi[k], cur[k]);
                    end
                end
            end
            tongbu = tb_at(cyc + 1);
        end
        chk("completion", {fin[0], fin[1]}, 2'b11);
        tongbu = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("idle_flags", {busy[k], cfg_ready[k], sweep_done[k], step_strobe[k]}, 4'b0100);
            chk("idle_inc", inc_phi[k], q[$]);
            last_inc[k] = q[$];
        end
    endtask
    initial begin
        logic [31:0] fs, fe;
        last_inc = '{0, 0};
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        reject(1'b0, 0, 0);
        run_sweep(32'd100, 32'd400, 32'd100, 24'd4, 8'd0, 1'b0);
        run_sweep(32'd100, 32'd400, 32'd100, 24'd4, 8'd1, 1'b1);
        run_sweep(32'd100, 32'd250, 32'd100, 24'd0, 8'd0, 1'b0);
        run_sweep(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 24'd1, 8'd0, 1'b0);
        run_sweep(32'd777, 32'd777, 32'd5, 24'd2, 8'd1, 1'b0);
        run_sweep(32'd5, 32'd10, 32'd0, 24'd1, 8'd2, 1'b1);
        reject(1'b1, 32'd500, 32'd100);
        for (int i = 0; i < 10; i++) begin
            fs = $urandom;
            fe = (fs > 32'hFFFFF000) ? 32'hFFFFFFFF : fs + $urandom_range(0, 1000);
            run_sweep(fs, fe, (i % 4 == 3) ? 32'd0 : 32'($urandom_range(50, 400)),
                      24'($urandom_range(0, 5)), 8'($urandom_range(0, 2)), 1'($urandom));
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 2; k++) chk("abort_idle_inc", inc_phi[k], 0);
        // ALIGN=0 instance is mid-RUN, ALIGN=1 instance is parked in WAIT_SYNC (no tongbu).
        @(negedge clk);
        set_cfg(32'd1000, 32'd100000, 32'd100, 24'd2, 8'd3);
        cfg_valid = 1'b1;
        start = 1'b1;
        repeat (12) begin
            @(negedge clk);
            start = 1'b0;
            cfg_valid = 1'b0;
        end
        for (int k = 0; k < 2; k++) chk("pre_abort_busy", busy[k], 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("abort_inc", inc_phi[k], 0);
            chk("abort_flags", {busy[k], sweep_done[k], step_strobe[k], cfg_ready[k]}, 4'b0001);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) chk("abort_no_done", {sweep_done[k], busy[k], inc_phi[k]}, 0);
        last_inc = '{0, 0};
        set_cfg(32'd10, 32'd90000, 32'd7, 24'd3, 8'd1);
        cfg_valid = 1'b1;
        start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
            cfg_valid = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_reset_vals("mid_reset");
        reject(1'b0, 0, 0);
        run_sweep(32'd100, 32'd400, 32'd100, 24'd3, 8'd0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
